// File: rtl/header_stripper.sv
// header_stripper
// Receive-side splitter for framed AXI-Stream traffic. Each frame on the input
// carries DATA_BEATS payload beats, then META_BEATS metadata beats, then one
// packet-counter beat. Payload and metadata go out on separate registered
// streams. The packet counter is captured and checked for sequence continuity.
//
// Ports:
//   clk, resetn                   clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready    framed input stream
//   s_axis_tlast                  frame marker, checked only with FRAME_TLAST_CHECK_EN
//   m_data_tdata/tvalid/tready    payload output stream
//   m_data_tlast                  last payload beat of a frame
//   m_meta_tdata/tvalid/tready    metadata output stream
//   m_meta_tlast                  last metadata beat of a frame
//   pkt_count, pkt_count_valid    last received packet counter and its update pulse
//   seq_err                       pulse on counter discontinuity or framing error
//   frames_rx                     completed-frame count, wraps at 2^32
//   fsm_state                     0 DATA, 1 META, 2 CNT
//
// Optional feature macro: FRAME_TLAST_CHECK_EN
//   When defined, s_axis_tlast must be low on DATA/META beats and high on the
//   CNT beat. A violating beat is dropped, seq_err pulses and the receiver
//   resynchronises at DATA. When undefined, s_axis_tlast is ignored.

module header_stripper #(
  parameter int DW         = 128,
  parameter int DATA_BEATS = 128,
  parameter int META_BEATS = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [DW-1:0] m_data_tdata,
  output logic          m_data_tvalid,
  input  logic          m_data_tready,
  output logic          m_data_tlast,
  output logic [DW-1:0] m_meta_tdata,
  output logic          m_meta_tvalid,
  input  logic          m_meta_tready,
  output logic          m_meta_tlast,
  output logic [DW-1:0] pkt_count,
  output logic          pkt_count_valid,
  output logic          seq_err,
  output logic [31:0]   frames_rx,
  output logic [1:0]    fsm_state
);

  localparam int MAXB = (DATA_BEATS > META_BEATS) ? DATA_BEATS : META_BEATS;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_META = 2'd1,
    ST_CNT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          first_frame_q, first_frame_d;
  logic [DW-1:0] expected_q, expected_d;
  logic [DW-1:0] data_tdata_q, data_tdata_d;
  logic          data_tvalid_q, data_tvalid_d;
  logic          data_tlast_q, data_tlast_d;
  logic [DW-1:0] meta_tdata_q, meta_tdata_d;
  logic          meta_tvalid_q, meta_tvalid_d;
  logic          meta_tlast_q, meta_tlast_d;
  logic [DW-1:0] pkt_count_q, pkt_count_d;
  logic          pkt_count_valid_q, pkt_count_valid_d;
  logic          seq_err_q, seq_err_d;
  logic [31:0]   frames_rx_q, frames_rx_d;

  logic in_ready;
  logic accept;
  logic frame_err;
  logic data_last_beat;
  logic meta_last_beat;

`ifdef FRAME_TLAST_CHECK_EN
  assign frame_err = (state_q == ST_CNT) ? !s_axis_tlast : s_axis_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign frame_err    = 1'b0;
`endif

  // Input readiness follows the output register the current beat targets, so
  // a stalled payload sink never holds back an already-registered meta beat.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_DATA: in_ready = !data_tvalid_q || m_data_tready;
      ST_META: in_ready = !meta_tvalid_q || m_meta_tready;
      ST_CNT:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Reset is synchronous, so ready is gated while resetn is low to keep the
  // upstream from handing over beats that would be thrown away.
  assign s_axis_tready  = resetn && in_ready;
  assign accept         = s_axis_tvalid && s_axis_tready;
  assign data_last_beat = (beat_cnt_q == CW'(DATA_BEATS - 1));
  assign meta_last_beat = (beat_cnt_q == CW'(META_BEATS - 1));

  always_comb begin
    state_d           = state_q;
    beat_cnt_d        = beat_cnt_q;
    first_frame_d     = first_frame_q;
    expected_d        = expected_q;
    data_tdata_d      = data_tdata_q;
    data_tlast_d      = data_tlast_q;
    data_tvalid_d     = data_tvalid_q && !m_data_tready;
    meta_tdata_d      = meta_tdata_q;
    meta_tlast_d      = meta_tlast_q;
    meta_tvalid_d     = meta_tvalid_q && !m_meta_tready;
    pkt_count_d       = pkt_count_q;
    pkt_count_valid_d = 1'b0;
    seq_err_d         = 1'b0;
    frames_rx_d       = frames_rx_q;

    if (accept) begin
      if (frame_err) begin
        seq_err_d     = 1'b1;
        state_d       = ST_DATA;
        beat_cnt_d    = '0;
        first_frame_d = 1'b1;
      end else begin
        case (state_q)
          ST_DATA: begin
            data_tdata_d  = s_axis_tdata;
            data_tvalid_d = 1'b1;
            data_tlast_d  = data_last_beat;
            if (data_last_beat) begin
              state_d    = ST_META;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CW'(1);
            end
          end
          ST_META: begin
            meta_tdata_d  = s_axis_tdata;
            meta_tvalid_d = 1'b1;
            meta_tlast_d  = meta_last_beat;
            if (meta_last_beat) begin
              state_d    = ST_CNT;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CW'(1);
            end
          end
          ST_CNT: begin
            pkt_count_d       = s_axis_tdata;
            pkt_count_valid_d = 1'b1;
            frames_rx_d       = frames_rx_q + 32'd1;
            seq_err_d         = !first_frame_q && (s_axis_tdata != expected_q);
            // Natural DW-bit wrap makes all-ones followed by zero continuous.
            expected_d        = s_axis_tdata + DW'(1);
            first_frame_d     = 1'b0;
            state_d           = ST_DATA;
            beat_cnt_d        = '0;
          end
          default: begin
            state_d    = ST_DATA;
            beat_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= ST_DATA;
      beat_cnt_q        <= '0;
      first_frame_q     <= 1'b1;
      expected_q        <= '0;
      data_tdata_q      <= '0;
      data_tvalid_q     <= 1'b0;
      data_tlast_q      <= 1'b0;
      meta_tdata_q      <= '0;
      meta_tvalid_q     <= 1'b0;
      meta_tlast_q      <= 1'b0;
      pkt_count_q       <= '0;
      pkt_count_valid_q <= 1'b0;
      seq_err_q         <= 1'b0;
      frames_rx_q       <= '0;
    end else begin
      state_q           <= state_d;
      beat_cnt_q        <= beat_cnt_d;
      first_frame_q     <= first_frame_d;
      expected_q        <= expected_d;
      data_tdata_q      <= data_tdata_d;
      data_tvalid_q     <= data_tvalid_d;
      data_tlast_q      <= data_tlast_d;
      meta_tdata_q      <= meta_tdata_d;
      meta_tvalid_q     <= meta_tvalid_d;
      meta_tlast_q      <= meta_tlast_d;
      pkt_count_q       <= pkt_count_d;
      pkt_count_valid_q <= pkt_count_valid_d;
      seq_err_q         <= seq_err_d;
      frames_rx_q       <= frames_rx_d;
    end
  end

  assign m_data_tdata    = data_tdata_q;
  assign m_data_tvalid   = data_tvalid_q;
  assign m_data_tlast    = data_tlast_q;
  assign m_meta_tdata    = meta_tdata_q;
  assign m_meta_tvalid   = meta_tvalid_q;
  assign m_meta_tlast    = meta_tlast_q;
  assign pkt_count       = pkt_count_q;
  assign pkt_count_valid = pkt_count_valid_q;
  assign seq_err         = seq_err_q;
  assign frames_rx       = frames_rx_q;
  assign fsm_state       = state_q;

endmodule
